// File: rtl/bp_me_cce_mem_mux_pkg.sv
// Shared helpers for the CCE<->memory concentrator.
// Channel index and FIFO pointer widths must be at least one bit, even for a single channel.
package bp_me_cce_mem_mux_pkg;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_me_cce_mem_mux_chan.sv
// One CCE channel of the concentrator: command FIFO, response FIFO and a response-space credit
// counter. A credit is consumed when a command issues and returned when its response is consumed.
module bp_me_cce_mem_mux_chan
    import bp_me_cce_mem_mux_pkg::*;
#(
    parameter int unsigned msg_width_p = 128,
    parameter int unsigned cmd_els_p   = 4,
    parameter int unsigned resp_els_p  = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [msg_width_p-1:0] cmd_i,
    input  logic                   cmd_v_i,
    output logic                   cmd_ready_o,
    output logic [msg_width_p-1:0] cmd_head_o,
    output logic                   cmd_v_o,
    input  logic                   cmd_deq_i,
    input  logic [msg_width_p-1:0] resp_i,
    input  logic                   resp_enq_i,
    output logic [msg_width_p-1:0] resp_o,
    output logic                   resp_v_o,
    input  logic                   resp_yumi_i,
    output logic                   credit_avail_o
);
    localparam int unsigned CmdPtrW  = clog2_min1(cmd_els_p);
    localparam int unsigned CmdCntW  = $clog2(cmd_els_p + 1);
    localparam int unsigned RespPtrW = clog2_min1(resp_els_p);
    localparam int unsigned RespCntW = $clog2(resp_els_p + 1);
    localparam int unsigned CreditW  = $clog2(resp_els_p + 1);

    logic [msg_width_p-1:0] cmd_mem_q  [cmd_els_p];
    logic [msg_width_p-1:0] resp_mem_q [resp_els_p];
    logic [CmdPtrW-1:0]     cmd_wptr_q, cmd_rptr_q;
    logic [CmdCntW-1:0]     cmd_cnt_q;
    logic [RespPtrW-1:0]    resp_wptr_q, resp_rptr_q;
    logic [RespCntW-1:0]    resp_cnt_q;
    logic [CreditW-1:0]     credit_q;
    logic                   cmd_enq, cmd_deq, resp_enq, resp_deq;

    assign cmd_ready_o    = ~reset_i & (cmd_cnt_q != CmdCntW'(cmd_els_p));
    assign cmd_v_o        = (cmd_cnt_q != '0);
    assign cmd_enq        = cmd_v_i & cmd_ready_o;
    assign cmd_deq        = cmd_deq_i & cmd_v_o;
    assign cmd_head_o     = cmd_mem_q[cmd_rptr_q];

    assign resp_v_o       = (resp_cnt_q != '0);
    assign resp_enq       = resp_enq_i & (resp_cnt_q != RespCntW'(resp_els_p));
    assign resp_deq       = resp_yumi_i & resp_v_o;
    assign resp_o         = resp_mem_q[resp_rptr_q];

    assign credit_avail_o = (credit_q != '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_wptr_q  <= '0;
            cmd_rptr_q  <= '0;
            cmd_cnt_q   <= '0;
            resp_wptr_q <= '0;
            resp_rptr_q <= '0;
            resp_cnt_q  <= '0;
            credit_q    <= CreditW'(resp_els_p);
        end else begin
            if (cmd_enq) begin
                cmd_wptr_q <= (cmd_wptr_q == CmdPtrW'(cmd_els_p - 1)) ? '0 : cmd_wptr_q + 1'b1;
            end
            if (cmd_deq) begin
                cmd_rptr_q <= (cmd_rptr_q == CmdPtrW'(cmd_els_p - 1)) ? '0 : cmd_rptr_q + 1'b1;
            end
            if (cmd_enq != cmd_deq) begin
                cmd_cnt_q <= cmd_enq ? cmd_cnt_q + 1'b1 : cmd_cnt_q - 1'b1;
            end
            if (resp_enq) begin
                resp_wptr_q <= (resp_wptr_q == RespPtrW'(resp_els_p - 1)) ? '0
                                                                          : resp_wptr_q + 1'b1;
            end
            if (resp_deq) begin
                resp_rptr_q <= (resp_rptr_q == RespPtrW'(resp_els_p - 1)) ? '0
                                                                          : resp_rptr_q + 1'b1;
            end
            if (resp_enq != resp_deq) begin
                resp_cnt_q <= resp_enq ? resp_cnt_q + 1'b1 : resp_cnt_q - 1'b1;
            end
            // Issue and return in the same cycle cancel out.
            if (cmd_deq && !resp_deq) begin
                credit_q <= credit_q - 1'b1;
            end else if (!cmd_deq && resp_deq) begin
                credit_q <= credit_q + 1'b1;
            end
        end
    end

    // Storage arrays need no reset; occupancy counters gate every read.
    always_ff @(posedge clk_i) begin
        if (cmd_enq) begin
            cmd_mem_q[cmd_wptr_q] <= cmd_i;
        end
        if (resp_enq) begin
            resp_mem_q[resp_wptr_q] <= resp_i;
        end
    end

endmodule

// File: rtl/bp_me_cce_mem_mux.sv
// N-channel CCE<->memory concentrator: round-robin locked arbitration onto one in-order memory
// port, an order FIFO recording the source channel of each issued command, and response routing.
module bp_me_cce_mem_mux
    import bp_me_cce_mem_mux_pkg::*;
#(
    parameter int unsigned num_cce_p         = 2,
    parameter int unsigned msg_width_p       = 128,
    parameter int unsigned cmd_els_p         = 4,
    parameter int unsigned resp_els_p        = 4,
    parameter int unsigned max_outstanding_p = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_cce_p*msg_width_p-1:0] cce_mem_cmd_i,
    input  logic [num_cce_p-1:0]             cce_mem_cmd_v_i,
    output logic [num_cce_p-1:0]             cce_mem_cmd_ready_o,
    output logic [num_cce_p*msg_width_p-1:0] cce_mem_resp_o,
    output logic [num_cce_p-1:0]             cce_mem_resp_v_o,
    input  logic [num_cce_p-1:0]             cce_mem_resp_yumi_i,
    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]           mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic                             error_o
);
    localparam int unsigned IdxW    = clog2_min1(num_cce_p);
    localparam int unsigned OrdPtrW = clog2_min1(max_outstanding_p);
    localparam int unsigned OrdCntW = $clog2(max_outstanding_p + 1);

    logic [msg_width_p-1:0] chan_cmd_head [num_cce_p];
    logic [num_cce_p-1:0]   chan_cmd_v, chan_credit, chan_deq, chan_resp_enq, eligible;

    logic [IdxW-1:0]    rr_q, lock_idx_q, pick_idx, grant_idx, rr_next;
    logic               lock_q, pick_v, issue, error_q;
    logic [IdxW-1:0]    ord_mem_q [max_outstanding_p];
    logic [OrdPtrW-1:0] ord_wptr_q, ord_rptr_q;
    logic [OrdCntW-1:0] ord_cnt_q;
    logic               ord_empty, ord_full;
    logic [IdxW-1:0]    ord_head;
    int unsigned        cand;

    assign ord_empty = (ord_cnt_q == '0);
    assign ord_full  = (ord_cnt_q == OrdCntW'(max_outstanding_p));
    assign ord_head  = ord_mem_q[ord_rptr_q];

    for (genvar i = 0; i < num_cce_p; i++) begin : g_chan
        bp_me_cce_mem_mux_chan #(
            .msg_width_p (msg_width_p),
            .cmd_els_p   (cmd_els_p),
            .resp_els_p  (resp_els_p)
        ) u_chan (
            .clk_i          (clk_i),
            .reset_i        (reset_i),
            .cmd_i          (cce_mem_cmd_i[i*msg_width_p +: msg_width_p]),
            .cmd_v_i        (cce_mem_cmd_v_i[i]),
            .cmd_ready_o    (cce_mem_cmd_ready_o[i]),
            .cmd_head_o     (chan_cmd_head[i]),
            .cmd_v_o        (chan_cmd_v[i]),
            .cmd_deq_i      (chan_deq[i]),
            .resp_i         (mem_resp_i),
            .resp_enq_i     (chan_resp_enq[i]),
            .resp_o         (cce_mem_resp_o[i*msg_width_p +: msg_width_p]),
            .resp_v_o       (cce_mem_resp_v_o[i]),
            .resp_yumi_i    (cce_mem_resp_yumi_i[i]),
            .credit_avail_o (chan_credit[i])
        );

        assign eligible[i]      = chan_cmd_v[i] & chan_credit[i] & ~ord_full;
        assign chan_deq[i]      = issue & (grant_idx == IdxW'(i));
        assign chan_resp_enq[i] = mem_resp_yumi_o & (ord_head == IdxW'(i));
    end

    // Round-robin search for the first eligible channel at or after the pointer.
    always_comb begin
        pick_v   = 1'b0;
        pick_idx = rr_q;
        cand     = 0;
        for (int k = 0; k < int'(num_cce_p); k++) begin
            cand = 32'(rr_q) + 32'(k);
            if (cand >= num_cce_p) begin
                cand = cand - num_cce_p;
            end
            if (!pick_v && eligible[cand[IdxW-1:0]]) begin
                pick_v   = 1'b1;
                pick_idx = cand[IdxW-1:0];
            end
        end
    end

    // A presented grant stays fixed until memory accepts it; eligibility cannot drop meanwhile.
    assign grant_idx       = lock_q ? lock_idx_q : pick_idx;
    assign mem_cmd_v_o     = lock_q | pick_v;
    assign mem_cmd_o       = chan_cmd_head[grant_idx];
    assign issue           = mem_cmd_v_o & mem_cmd_ready_i;
    assign rr_next         = (32'(grant_idx) + 32'd1 >= num_cce_p) ? '0 : grant_idx + 1'b1;

    assign mem_resp_yumi_o = mem_resp_v_i & ~ord_empty;
    assign error_o         = error_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            ord_wptr_q <= '0;
            ord_rptr_q <= '0;
            ord_cnt_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            lock_q     <= mem_cmd_v_o & ~mem_cmd_ready_i;
            lock_idx_q <= grant_idx;
            if (issue) begin
                rr_q       <= rr_next;
                ord_wptr_q <= (ord_wptr_q == OrdPtrW'(max_outstanding_p - 1)) ? '0
                                                                              : ord_wptr_q + 1'b1;
            end
            if (mem_resp_yumi_o) begin
                ord_rptr_q <= (ord_rptr_q == OrdPtrW'(max_outstanding_p - 1)) ? '0
                                                                              : ord_rptr_q + 1'b1;
            end
            if (issue != mem_resp_yumi_o) begin
                ord_cnt_q <= issue ? ord_cnt_q + 1'b1 : ord_cnt_q - 1'b1;
            end
            if (mem_resp_v_i && ord_empty) begin
                error_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) begin
            ord_mem_q[ord_wptr_q] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_bp_me_cce_mem_mux.sv
// Scoreboard bench for the 2-channel concentrator: directed stimulus pushes expected memory
// commands and per-channel responses; a monitor with a latency-1 memory model pops and compares.
module tb_bp_me_cce_mem_mux;
    localparam int N = 2;
    localparam int W = 128;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [N*W-1:0]   cce_mem_cmd_i;
    logic [N-1:0]     cce_mem_cmd_v_i;
    logic [N-1:0]     cce_mem_cmd_ready_o;
    logic [N*W-1:0]   cce_mem_resp_o;
    logic [N-1:0]     cce_mem_resp_v_o;
    logic [N-1:0]     cce_mem_resp_yumi_i;
    logic [W-1:0]     mem_cmd_o;
    logic             mem_cmd_v_o;
    logic             mem_cmd_ready_i;
    logic [W-1:0]     mem_resp_i;
    logic             mem_resp_v_i;
    logic             mem_resp_yumi_o;
    logic             error_o;

    bp_me_cce_mem_mux #(
        .num_cce_p         (N),
        .msg_width_p       (W),
        .cmd_els_p         (4),
        .resp_els_p        (4),
        .max_outstanding_p (8)
    ) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .cce_mem_cmd_i       (cce_mem_cmd_i),
        .cce_mem_cmd_v_i     (cce_mem_cmd_v_i),
        .cce_mem_cmd_ready_o (cce_mem_cmd_ready_o),
        .cce_mem_resp_o      (cce_mem_resp_o),
        .cce_mem_resp_v_o    (cce_mem_resp_v_o),
        .cce_mem_resp_yumi_i (cce_mem_resp_yumi_i),
        .mem_cmd_o           (mem_cmd_o),
        .mem_cmd_v_o         (mem_cmd_v_o),
        .mem_cmd_ready_i     (mem_cmd_ready_i),
        .mem_resp_i          (mem_resp_i),
        .mem_resp_v_i        (mem_resp_v_i),
        .mem_resp_yumi_o     (mem_resp_yumi_o),
        .error_o             (error_o)
    );

    always #5 clk_i = ~clk_i;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_cmd[$];
    logic [W-1:0] exp_resp0[$];
    logic [W-1:0] exp_resp1[$];
    logic [W-1:0] pend[$];
    bit           resp_en    = 1'b1;
    bit           force_resp = 1'b0;

    function automatic logic [W-1:0] msg(input int ch, input int n);
        return {8'(ch), 8'(n), 96'hdead_beef_0123_4567_89ab_cdef, 16'(n * 37)};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [W-1:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h, required nothing", name, act);
    endtask

    // Monitor and memory model: compares every handshake, answers each command one cycle later.
    initial begin
        mem_resp_v_i = 1'b0;
        mem_resp_i   = '0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                pend.delete();
            end else begin
                if (mem_resp_v_i && mem_resp_yumi_o && !force_resp && pend.size() > 0) begin
                    void'(pend.pop_front());
                end
                if (mem_cmd_v_o && mem_cmd_ready_i) begin
                    if (exp_cmd.size() == 0) unexpected("mem_cmd", mem_cmd_o);
                    else check("mem_cmd order", mem_cmd_o, exp_cmd.pop_front());
                    pend.push_back(~mem_cmd_o);
                end
                if (cce_mem_resp_v_o[0] && cce_mem_resp_yumi_i[0]) begin
                    if (exp_resp0.size() == 0) unexpected("ch0 resp", cce_mem_resp_o[W-1:0]);
                    else check("ch0 resp", cce_mem_resp_o[W-1:0], exp_resp0.pop_front());
                end
                if (cce_mem_resp_v_o[1] && cce_mem_resp_yumi_i[1]) begin
                    if (exp_resp1.size() == 0) unexpected("ch1 resp", cce_mem_resp_o[2*W-1:W]);
                    else check("ch1 resp", cce_mem_resp_o[2*W-1:W], exp_resp1.pop_front());
                end
            end
            @(posedge clk_i);
            #1;
            mem_resp_v_i = force_resp || (resp_en && pend.size() > 0);
            mem_resp_i   = (pend.size() > 0) ? pend[0] : '0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic enq(input int ch, input logic [W-1:0] d);
        int n = 0;
        cce_mem_cmd_i[ch*W +: W] = d;
        cce_mem_cmd_v_i[ch]      = 1'b1;
        @(negedge clk_i);
        while (!cce_mem_cmd_ready_o[ch] && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        if (n >= 50) checkv("cmd_ready timeout", 32'(cce_mem_cmd_ready_o[ch]), 32'd1);
        @(posedge clk_i);
        #1;
        cce_mem_cmd_v_i[ch] = 1'b0;
    endtask

    task automatic enq_both(input logic [W-1:0] d0, input logic [W-1:0] d1);
        int n = 0;
        cce_mem_cmd_i   = {d1, d0};
        cce_mem_cmd_v_i = 2'b11;
        @(negedge clk_i);
        while (cce_mem_cmd_ready_o != 2'b11 && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        if (n >= 50) checkv("cmd_ready both timeout", 32'(cce_mem_cmd_ready_o), 32'd3);
        @(posedge clk_i);
        #1;
        cce_mem_cmd_v_i = 2'b00;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_cmd.size() + exp_resp0.size() + exp_resp1.size()) != 0 && n < 300) begin
            n++;
            cycles(1);
        end
        checkv({name, " pending after drain"},
               32'(exp_cmd.size() + exp_resp0.size() + exp_resp1.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] d, h0, i0;
        reset_i             = 1'b1;
        cce_mem_cmd_i       = '0;
        cce_mem_cmd_v_i     = '0;
        cce_mem_resp_yumi_i = '0;
        mem_cmd_ready_i     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        checkv("reset mem_cmd_v_o", 32'(mem_cmd_v_o), 32'd0);
        checkv("reset cmd_ready_o", 32'(cce_mem_cmd_ready_o), 32'd0);
        checkv("reset resp_v_o", 32'(cce_mem_resp_v_o), 32'd0);
        checkv("reset error_o", 32'(error_o), 32'd0);
        reset_i = 1'b0;
        cycles(1);
        checkv("post-reset cmd_ready_o", 32'(cce_mem_cmd_ready_o), 32'd3);

        // 1: three reads on ch0 only
        mem_cmd_ready_i     = 1'b1;
        cce_mem_resp_yumi_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            d = msg(0, 'hA0 + i);
            exp_cmd.push_back(d);
            exp_resp0.push_back(~d);
            enq(0, d);
        end
        drain("t1");
        checkv("t1 error_o", 32'(error_o), 32'd0);

        // 2: two per channel queued behind a stalled memory -> ch0,ch1,ch0,ch1
        mem_cmd_ready_i = 1'b0;
        exp_cmd.push_back(msg(0, 'hB0));
        exp_cmd.push_back(msg(1, 'hC0));
        exp_cmd.push_back(msg(0, 'hB1));
        exp_cmd.push_back(msg(1, 'hC1));
        exp_resp0.push_back(~msg(0, 'hB0));
        exp_resp0.push_back(~msg(0, 'hB1));
        exp_resp1.push_back(~msg(1, 'hC0));
        exp_resp1.push_back(~msg(1, 'hC1));
        enq(0, msg(0, 'hB0));
        enq(0, msg(0, 'hB1));
        enq(1, msg(1, 'hC0));
        enq(1, msg(1, 'hC1));
        mem_cmd_ready_i = 1'b1;
        drain("t2");
        // Pointer back at 0: simultaneous arrivals go ch0 first.
        mem_cmd_ready_i = 1'b0;
        exp_cmd.push_back(msg(0, 'hE0));
        exp_cmd.push_back(msg(1, 'hE1));
        exp_resp0.push_back(~msg(0, 'hE0));
        exp_resp1.push_back(~msg(1, 'hE1));
        enq_both(msg(0, 'hE0), msg(1, 'hE1));
        mem_cmd_ready_i = 1'b1;
        drain("t2 rr");

        // 3: credit exhaustion on ch0
        cce_mem_resp_yumi_i = 2'b10;
        for (int i = 0; i < 6; i++) begin
            d = msg(0, 'h30 + i);
            exp_resp0.push_back(~d);
            if (i < 4) exp_cmd.push_back(d);
            enq(0, d);
        end
        cycles(20);
        checkv("t3 issued before stall", 32'(exp_cmd.size()), 32'd0);
        checkv("t3 mem_cmd_v_o stalled", 32'(mem_cmd_v_o), 32'd0);
        checkv("t3 ch0 resp_v", 32'(cce_mem_resp_v_o[0]), 32'd1);
        d = msg(1, 'h40);
        exp_cmd.push_back(d);
        exp_resp1.push_back(~d);
        enq(1, d);
        cycles(10);
        checkv("t3 ch1 still issued", 32'(exp_cmd.size() + exp_resp1.size()), 32'd0);
        checkv("t3 mem_cmd_v_o after ch1", 32'(mem_cmd_v_o), 32'd0);
        exp_cmd.push_back(msg(0, 'h34));
        cce_mem_resp_yumi_i[0] = 1'b1;
        cycles(1);
        cce_mem_resp_yumi_i[0] = 1'b0;
        cycles(10);
        checkv("t3 fifth issued", 32'(exp_cmd.size()), 32'd0);
        checkv("t3 sixth held", 32'(mem_cmd_v_o), 32'd0);
        checkv("t3 ch0 resps held", 32'(exp_resp0.size()), 32'd5);
        exp_cmd.push_back(msg(0, 'h35));
        cce_mem_resp_yumi_i = 2'b11;
        drain("t3");

        // 4: grant lock on ch0 while ch1 arrives
        mem_cmd_ready_i = 1'b0;
        h0 = msg(0, 'h50);
        i0 = msg(1, 'h51);
        exp_cmd.push_back(h0);
        exp_cmd.push_back(i0);
        exp_resp0.push_back(~h0);
        exp_resp1.push_back(~i0);
        enq(0, h0);
        enq(1, i0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            checkv("t4 mem_cmd_v_o held", 32'(mem_cmd_v_o), 32'd1);
            check("t4 mem_cmd_o locked", mem_cmd_o, h0);
            @(posedge clk_i);
            #1;
        end
        mem_cmd_ready_i = 1'b1;
        drain("t4");

        // 5: response with nothing outstanding
        force_resp = 1'b1;
        cycles(1);
        @(negedge clk_i);
        checkv("t5 mem_resp_yumi_o", 32'(mem_resp_yumi_o), 32'd0);
        @(posedge clk_i);
        #1;
        force_resp = 1'b0;
        checkv("t5 error_o set", 32'(error_o), 32'd1);
        cycles(5);
        checkv("t5 error_o sticky", 32'(error_o), 32'd1);
        checkv("t5 no stray resp", 32'(cce_mem_resp_v_o), 32'd0);

        // 6: asynchronous reset with two commands outstanding
        resp_en = 1'b0;
        exp_cmd.push_back(msg(0, 'h60));
        exp_cmd.push_back(msg(0, 'h61));
        enq(0, msg(0, 'h60));
        enq(0, msg(0, 'h61));
        cycles(3);
        checkv("t6 two outstanding", 32'(exp_cmd.size()), 32'd0);
        #2;
        reset_i = 1'b1;
        #1;
        checkv("t6 async mem_cmd_v_o", 32'(mem_cmd_v_o), 32'd0);
        checkv("t6 async resp_v_o", 32'(cce_mem_resp_v_o), 32'd0);
        checkv("t6 async cmd_ready_o", 32'(cce_mem_cmd_ready_o), 32'd0);
        checkv("t6 async mem_resp_yumi_o", 32'(mem_resp_yumi_o), 32'd0);
        checkv("t6 async error_o", 32'(error_o), 32'd0);
        exp_cmd.delete();
        exp_resp0.delete();
        exp_resp1.delete();
        cycles(2);
        reset_i             = 1'b0;
        resp_en             = 1'b1;
        cce_mem_resp_yumi_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            d = msg(0, 'h70 + i);
            exp_cmd.push_back(d);
            exp_resp0.push_back(~d);
            enq(0, d);
        end
        cycles(10);
        checkv("t6 full credit after reset", 32'(exp_cmd.size()), 32'd0);
        checkv("t6 ch0 resp_v", 32'(cce_mem_resp_v_o[0]), 32'd1);
        cce_mem_resp_yumi_i = 2'b11;
        drain("t6");
        checkv("t6 error_o", 32'(error_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
